// File: rtl/maze_pkg.sv
// Shared cell/orientation codes and helpers for the robot maze map engine.
package maze_pkg;

  localparam logic [2:0] WALL     = 3'd0;
  localparam logic [2:0] PATH     = 3'd1;
  localparam logic [2:0] BARRIER3 = 3'd2;
  localparam logic [2:0] BARRIER6 = 3'd3;
  localparam logic [2:0] BARRIER9 = 3'd4;
  localparam logic [2:0] BLACK    = 3'd7;

  localparam logic [1:0] ORIENT_N = 2'd0;
  localparam logic [1:0] ORIENT_W = 2'd1;
  localparam logic [1:0] ORIENT_S = 2'd2;
  localparam logic [1:0] ORIENT_E = 2'd3;

  function automatic logic is_barrier(input logic [7:0] c);
    return (c == 8'(BARRIER3)) || (c == 8'(BARRIER6)) || (c == 8'(BARRIER9));
  endfunction

  // Codes 5 and 6 are unused and behave like PATH.
  function automatic logic is_passable(input logic [7:0] c);
    return (c == 8'(PATH)) || (c == 8'd5) || (c == 8'd6) || (c == 8'(BLACK));
  endfunction

  function automatic logic [7:0] downgrade(input logic [7:0] c);
    case (c)
      8'(BARRIER9): return 8'(BARRIER6);
      8'(BARRIER6): return 8'(BARRIER3);
      default:      return 8'(PATH);
    endcase
  endfunction

  // One step in direction dir; the extra index bit makes 0-1 land out of grid.
  function automatic logic [10:0] step(input logic [4:0] row, input logic [5:0] col,
                                       input logic [1:0] dir);
    logic [4:0] r;
    logic [5:0] c;
    r = row;
    c = col;
    case (dir)
      ORIENT_N: r = row - 5'd1;
      ORIENT_W: c = col - 6'd1;
      ORIENT_S: r = row + 5'd1;
      default:  c = col + 6'd1;
    endcase
    return {r, c};
  endfunction

endpackage

// File: rtl/maze_cell_ram.sv
// Grid cell storage: three combinational read ports, one synchronous write port,
// asynchronously cleared to all WALL with the start cell as PATH.
module maze_cell_ram
  import maze_pkg::*;
#(
  parameter int ROWS      = 10,
  parameter int COLS      = 20,
  parameter int CELL_W    = 3,
  parameter int START_ROW = ROWS - 1,
  parameter int START_COL = 0
) (
  input  logic              selected_clock,
  input  logic              reset,
  input  logic [3:0]        front_row,
  input  logic [4:0]        front_col,
  output logic [CELL_W-1:0] front_data,
  input  logic [3:0]        left_row,
  input  logic [4:0]        left_col,
  output logic [CELL_W-1:0] left_data,
  input  logic [3:0]        under_row,
  input  logic [4:0]        under_col,
  output logic [CELL_W-1:0] under_data,
  input  logic              we,
  input  logic [3:0]        wr_row,
  input  logic [4:0]        wr_col,
  input  logic [CELL_W-1:0] wr_data
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int START_IDX = START_ROW * COLS + START_COL;

  logic [CELL_W-1:0] cells [CELLS];

  function automatic logic [IDX_W-1:0] idx(input logic [3:0] r, input logic [4:0] c);
    return IDX_W'(int'(r) * COLS + int'(c));
  endfunction

  always_ff @(posedge selected_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) begin
        cells[IDX_W'(i)] <= (i == START_IDX) ? CELL_W'(PATH) : CELL_W'(WALL);
      end
    end else if (we) begin
      cells[idx(wr_row, wr_col)] <= wr_data;
    end
  end

  assign front_data = cells[idx(front_row, front_col)];
  assign left_data  = cells[idx(left_row, left_col)];
  assign under_data = cells[idx(under_row, under_col)];

endmodule

// File: rtl/maze_map_engine.sv
// Robot maze map engine: executes turn/advance/remove commands on a cell grid,
// supports cursor-based map editing and derives the robot's sensor bits.
module maze_map_engine #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int CELL_W        = 3,
  parameter int REMOVE_CYCLES = 3,
  parameter int START_ROW     = ROWS - 1,
  parameter int START_COL     = 0
) (
  input  logic              selected_clock,
  input  logic              reset,
  input  logic              girar,
  input  logic              avancar,
  input  logic              remover,
  input  logic              edit_mode,
  input  logic [3:0]        edit_dir,
  input  logic              edit_write,
  input  logic [CELL_W-1:0] edit_value,
  output logic              head_out,
  output logic              left_out,
  output logic              under_out,
  output logic              barrier_out,
  output logic              blocked,
  output logic              busy,
  output logic [3:0]        robo_row,
  output logic [4:0]        robo_col,
  output logic [1:0]        robo_orient,
  output logic [3:0]        cursor_row,
  output logic [4:0]        cursor_col
);
  import maze_pkg::*;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_REMOVE = 2'd1;
  localparam logic [1:0] ST_EDIT   = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [10:0]       front_pos, left_pos;
  logic              front_in, left_in;
  logic [3:0]        front_ram_row, left_ram_row;
  logic [4:0]        front_ram_col, left_ram_col;
  logic [CELL_W-1:0] front_data, left_data, under_data;
  logic [CELL_W-1:0] front_cell, left_cell, down_cell;
  logic              remove_go, rm_hit, edit_wr, we;
  logic [3:0]        cnt_next, rm_cnt;
  logic [1:0]        rm_state;
  logic [3:0]        wr_row, cur_row_next;
  logic [4:0]        wr_col, cur_col_next;
  logic [CELL_W-1:0] wr_data;

  assign front_pos = step({1'b0, robo_row}, {1'b0, robo_col}, robo_orient);
  assign left_pos  = step({1'b0, robo_row}, {1'b0, robo_col}, robo_orient + 2'd1);

  assign front_in = (front_pos[10:6] < 5'(ROWS)) && (front_pos[5:0] < 6'(COLS));
  assign left_in  = (left_pos[10:6] < 5'(ROWS)) && (left_pos[5:0] < 6'(COLS));

  // Out-of-grid neighbours read a safe address and are then forced to WALL.
  assign front_ram_row = front_in ? front_pos[9:6] : 4'd0;
  assign front_ram_col = front_in ? front_pos[4:0] : 5'd0;
  assign left_ram_row  = left_in ? left_pos[9:6] : 4'd0;
  assign left_ram_col  = left_in ? left_pos[4:0] : 5'd0;

  maze_cell_ram #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W),
    .START_ROW(START_ROW), .START_COL(START_COL)
  ) u_ram (
    .selected_clock(selected_clock),
    .reset(reset),
    .front_row(front_ram_row), .front_col(front_ram_col), .front_data(front_data),
    .left_row(left_ram_row), .left_col(left_ram_col), .left_data(left_data),
    .under_row(robo_row), .under_col(robo_col), .under_data(under_data),
    .we(we), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  always_comb begin
    front_cell = front_in ? front_data : CELL_W'(WALL);
    left_cell  = left_in ? left_data : CELL_W'(WALL);
    down_cell  = CELL_W'(downgrade(8'(front_cell)));

    remove_go = !edit_mode && remover && !girar && !avancar &&
                is_barrier(8'(front_cell)) && (state == ST_RUN || state == ST_REMOVE);
    cnt_next  = (state == ST_REMOVE) ? cnt + 4'd1 : 4'd1;
    rm_hit    = remove_go && (cnt_next == 4'(REMOVE_CYCLES));
    rm_cnt    = rm_hit ? 4'd0 : cnt_next;
    rm_state  = (rm_hit && down_cell == CELL_W'(PATH)) ? ST_RUN : ST_REMOVE;

    edit_wr = (state == ST_EDIT) && edit_mode && edit_write;
    we      = edit_wr || rm_hit;
    wr_row  = edit_wr ? cursor_row : front_ram_row;
    wr_col  = edit_wr ? cursor_col : front_ram_col;
    wr_data = edit_wr ? edit_value : down_cell;

    cur_row_next = cursor_row;
    cur_col_next = cursor_col;
    case (edit_dir)
      4'b1000: if (cursor_row != 4'd0) cur_row_next = cursor_row - 4'd1;
      4'b0100: if (cursor_row != 4'(ROWS - 1)) cur_row_next = cursor_row + 4'd1;
      4'b0010: if (cursor_col != 5'd0) cur_col_next = cursor_col - 5'd1;
      4'b0001: if (cursor_col != 5'(COLS - 1)) cur_col_next = cursor_col + 5'd1;
      default: ;
    endcase
  end

  always_ff @(posedge selected_clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= 4'd0;
      robo_row    <= 4'(START_ROW);
      robo_col    <= 5'(START_COL);
      robo_orient <= ORIENT_N;
      cursor_row  <= 4'd0;
      cursor_col  <= 5'd0;
      blocked     <= 1'b0;
    end else begin
      blocked <= 1'b0;
      if (edit_mode) begin
        state <= ST_EDIT;
        cnt   <= 4'd0;
        if (state == ST_EDIT) begin
          cursor_row <= cur_row_next;
          cursor_col <= cur_col_next;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (girar) begin
              robo_orient <= robo_orient + 2'd1;
            end else if (avancar) begin
              if (front_in && is_passable(8'(front_cell))) begin
                robo_row <= front_pos[9:6];
                robo_col <= front_pos[4:0];
              end else begin
                blocked <= 1'b1;
              end
            end else if (remove_go) begin
              state <= rm_state;
              cnt   <= rm_cnt;
            end
          end
          ST_REMOVE: begin
            if (remove_go) begin
              state <= rm_state;
              cnt   <= rm_cnt;
            end else begin
              state <= ST_RUN;
              cnt   <= 4'd0;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign busy        = (state == ST_REMOVE);
  assign head_out    = (front_cell == CELL_W'(WALL));
  assign left_out    = (left_cell == CELL_W'(WALL));
  assign under_out   = (under_data == CELL_W'(BLACK));
  assign barrier_out = is_barrier(8'(front_cell));

endmodule

// File: tb/tb_maze_map_engine.sv
// Directed vector bench for maze_map_engine: a table of {inputs, expected outputs}
// applied one per clock, plus hand-written reset sequences.
module tb_maze_map_engine;

  localparam int N = 0;
  localparam int W = 1;
  localparam int S = 2;
  localparam int E = 3;

  logic       clk;
  logic       reset;
  logic       girar, avancar, remover, edit_mode, edit_write;
  logic [3:0] edit_dir;
  logic [2:0] edit_value;
  logic       head_out, left_out, under_out, barrier_out, blocked, busy;
  logic [3:0] robo_row, cursor_row;
  logic [4:0] robo_col, cursor_col;
  logic [1:0] robo_orient;

  maze_map_engine dut (
    .selected_clock(clk), .reset(reset),
    .girar(girar), .avancar(avancar), .remover(remover),
    .edit_mode(edit_mode), .edit_dir(edit_dir), .edit_write(edit_write),
    .edit_value(edit_value),
    .head_out(head_out), .left_out(left_out), .under_out(under_out),
    .barrier_out(barrier_out), .blocked(blocked), .busy(busy),
    .robo_row(robo_row), .robo_col(robo_col), .robo_orient(robo_orient),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       g, a, r, em;
    logic [3:0] dir;
    logic       wr;
    logic [2:0] val;
  } in_t;

  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
    logic [1:0] orient;
    logic [3:0] crow;
    logic [4:0] ccol;
    logic       head, left, under, bar, blk, busy;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t  vec_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic in_t fi(bit g, bit a, bit r, bit em, bit [3:0] d, bit w, bit [2:0] v);
    in_t x;
    x.g = g; x.a = a; x.r = r; x.em = em; x.dir = d; x.wr = w; x.val = v;
    return x;
  endfunction

  function automatic out_t fo(int row, int col, int orient, int cr, int cc,
                              bit h, bit l, bit u, bit b, bit k, bit y);
    out_t x;
    x.row = 4'(row); x.col = 5'(col); x.orient = 2'(orient);
    x.crow = 4'(cr); x.ccol = 5'(cc);
    x.head = h; x.left = l; x.under = u; x.bar = b; x.blk = k; x.busy = y;
    return x;
  endfunction

  function automatic string fmt(out_t x);
    return $sformatf("robot(%0d,%0d) o%0d cur(%0d,%0d) h%0b l%0b u%0b bar%0b blk%0b busy%0b",
                     x.row, x.col, x.orient, x.crow, x.ccol,
                     x.head, x.left, x.under, x.bar, x.blk, x.busy);
  endfunction

  task automatic add(string name, in_t i, out_t e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    vec_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic drive(in_t i);
    girar = i.g; avancar = i.a; remover = i.r; edit_mode = i.em;
    edit_dir = i.dir; edit_write = i.wr; edit_value = i.val;
  endtask

  task automatic check(string name, out_t exp);
    out_t act;
    act = {robo_row, robo_col, robo_orient, cursor_row, cursor_col,
           head_out, left_out, under_out, barrier_out, blocked, busy};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
  endtask

  task automatic build_vectors();
    in_t idle, gir, adv, rem, em;
    idle = fi(0, 0, 0, 0, 4'b0000, 0, 0);
    gir  = fi(1, 0, 0, 0, 4'b0000, 0, 0);
    adv  = fi(0, 1, 0, 0, 4'b0000, 0, 0);
    rem  = fi(0, 0, 1, 0, 4'b0000, 0, 0);
    em   = fi(0, 0, 0, 1, 4'b0000, 0, 0);

    // Start cell, facing a wall; turning all the way round.
    add("idle",        idle, fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("adv_wall",    adv,  fo(9, 0, N, 0, 0, 1, 1, 0, 0, 1, 0));
    add("blk_clear",   idle, fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("turn_w",      gir,  fo(9, 0, W, 0, 0, 1, 1, 0, 0, 0, 0));
    add("turn_s",      gir,  fo(9, 0, S, 0, 0, 1, 1, 0, 0, 0, 0));
    add("turn_e",      gir,  fo(9, 0, E, 0, 0, 1, 1, 0, 0, 0, 0));
    add("turn_n",      gir,  fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));

    // Edit: cursor saturation, multi-bit dir, ignored robot command, writes.
    add("edit_enter",  em, fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("cur_up_sat",  fi(0, 1, 0, 1, 4'b1000, 0, 0), fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("cur_lt_sat",  fi(0, 0, 0, 1, 4'b0010, 0, 0), fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("cur_multi",   fi(0, 0, 0, 1, 4'b1001, 0, 0), fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    add("cur_right",   fi(0, 0, 0, 1, 4'b0001, 0, 0), fo(9, 0, N, 0, 1, 1, 1, 0, 0, 0, 0));
    add("cur_left",    fi(0, 0, 0, 1, 4'b0010, 0, 0), fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      add($sformatf("cur_down%0d", i), fi(0, 0, 0, 1, 4'b0100, 0, 0),
          fo(9, 0, N, i, 0, 1, 1, 0, 0, 0, 0));
    add("wr_path_mv",  fi(0, 0, 0, 1, 4'b1000, 1, 1), fo(9, 0, N, 7, 0, 0, 1, 0, 0, 0, 0));
    add("wr_b9_70",    fi(0, 0, 0, 1, 4'b0000, 1, 4), fo(9, 0, N, 7, 0, 0, 1, 0, 0, 0, 0));
    add("cur_to_80",   fi(0, 0, 0, 1, 4'b0100, 0, 0), fo(9, 0, N, 8, 0, 0, 1, 0, 0, 0, 0));
    add("cur_to_81",   fi(0, 0, 0, 1, 4'b0001, 0, 0), fo(9, 0, N, 8, 1, 0, 1, 0, 0, 0, 0));
    add("wr_b9_81",    fi(0, 0, 0, 1, 4'b0000, 1, 4), fo(9, 0, N, 8, 1, 0, 1, 0, 0, 0, 0));
    add("edit_leave",  idle, fo(9, 0, N, 8, 1, 0, 1, 0, 0, 0, 0));
    add("adv_to_80",   adv,  fo(8, 0, N, 8, 1, 0, 1, 0, 1, 0, 0));

    // Full removal of BARRIER9: 9 held cycles.
    for (int i = 1; i <= 9; i++)
      add($sformatf("rm_full%0d", i), rem, fo(8, 0, N, 8, 1, 0, 1, 0, i < 9, 0, i < 9));

    add("turn_w2",     gir,  fo(8, 0, W, 8, 1, 1, 0, 0, 0, 0, 0));
    add("turn_s2",     gir,  fo(8, 0, S, 8, 1, 0, 0, 0, 0, 0, 0));
    add("turn_e2",     gir,  fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 0));

    // Partial hold discarded, then exactly one downgrade, then 6 more cycles to PATH.
    add("rm_part1",    rem,  fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 1));
    add("rm_part2",    rem,  fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 1));
    add("rm_release",  idle, fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 3; i++)
      add($sformatf("rm_one%0d", i), rem, fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 1));
    add("rm_release2", idle, fo(8, 0, E, 8, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 6; i++)
      add($sformatf("rm_b6_%0d", i), rem, fo(8, 0, E, 8, 1, 0, 0, 0, i < 6, 0, i < 6));

    // Black cell under the robot, then a column of PATH up to row 0.
    add("adv_to_81",   adv,  fo(8, 1, E, 8, 1, 1, 1, 0, 0, 0, 0));
    add("edit_enter2", em,   fo(8, 1, E, 8, 1, 1, 1, 0, 0, 0, 0));
    add("wr_black",    fi(0, 0, 0, 1, 4'b0000, 1, 7), fo(8, 1, E, 8, 1, 1, 1, 1, 0, 0, 0));
    add("cur_to_71",   fi(0, 0, 0, 1, 4'b1000, 0, 0), fo(8, 1, E, 7, 1, 1, 1, 1, 0, 0, 0));
    for (int k = 1; k <= 7; k++)
      add($sformatf("wr_col%0d", k), fi(0, 0, 0, 1, 4'b1000, 1, 1),
          fo(8, 1, E, 7 - k, 1, 1, 0, 1, 0, 0, 0));
    add("wr_01",       fi(0, 0, 0, 1, 4'b0000, 1, 1), fo(8, 1, E, 0, 1, 1, 0, 1, 0, 0, 0));
    add("edit_leave2", idle, fo(8, 1, E, 0, 1, 1, 0, 1, 0, 0, 0));
    add("turn_n3",     gir,  fo(8, 1, N, 0, 1, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      add($sformatf("adv_up%0d", k), adv,
          fo(8 - k, 1, N, 0, 1, (8 - k) == 0, (8 - k) != 7, 0, 0, 0, 0));
    add("adv_row0",    adv,  fo(0, 1, N, 0, 1, 1, 1, 0, 0, 1, 0));
    add("blk_clear2",  idle, fo(0, 1, N, 0, 1, 1, 1, 0, 0, 0, 0));

    // Removal aborted by entering edit mode.
    add("turn_w4",     gir,  fo(0, 1, W, 0, 1, 1, 0, 0, 0, 0, 0));
    add("edit_enter3", em,   fo(0, 1, W, 0, 1, 1, 0, 0, 0, 0, 0));
    add("cur_to_00",   fi(0, 0, 0, 1, 4'b0010, 0, 0), fo(0, 1, W, 0, 0, 1, 0, 0, 0, 0, 0));
    add("wr_b3_00",    fi(0, 0, 0, 1, 4'b0000, 1, 2), fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 0));
    add("edit_leave3", idle, fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 0));
    add("rm_abort1",   rem,  fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 1));
    add("rm_abort2",   rem,  fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 1));
    add("rm_to_edit",  fi(0, 0, 1, 1, 4'b0000, 0, 0), fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 0));
    add("cur_up_00",   fi(0, 0, 0, 1, 4'b1000, 0, 0), fo(0, 1, W, 0, 0, 0, 0, 0, 1, 0, 0));
  endtask

  initial begin
    out_t reset_exp;
    reset_exp = fo(9, 0, N, 0, 0, 1, 1, 0, 0, 0, 0);
    reset = 1'b1;
    drive(fi(0, 0, 0, 0, 4'b0000, 0, 0));
    build_vectors();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("reset", reset_exp);

    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i].in);
      @(posedge clk);
      #1 check(name_q[i], vec_q[i].exp);
    end

    // Asynchronous reset while editing: values must return without a clock edge.
    reset = 1'b1;
    #1 check("reset_mid_edit", reset_exp);
    #1 reset = 1'b0;
    drive(fi(0, 0, 0, 0, 4'b0000, 0, 0));
    @(posedge clk);
    #1 check("idle_after_reset", reset_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
